// File: rtl/ms_ptimers_pkg.sv
// Purpose: shared register map and field positions for the ms periodic timer bank.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ms_ptimers_pkg;

    // Register select values on the 1-bit address
    localparam logic ADDR_CFG = 1'b0;
    localparam logic ADDR_CLR = 1'b1;

    // CFG write field positions
    localparam int PERIOD_LSB = 0;
    localparam int INDEX_LSB  = 16;
    localparam int INDEX_W    = 4;
    localparam int EN_BIT     = 24;

    // Missed flags live in the upper half of STAT and of the CLR word
    localparam int MISSED_LSB = 16;

    // Width of each half-word flag field in the read data
    localparam int FLAG_W     = 16;

endpackage

// File: rtl/ms_ptimer_chan.sv
// Purpose: one periodic ms timer channel (period, counter, enable, ready, missed).
// Latency: ready/missed update on the clock edge that samples the tick; visible next cycle.
// Backpressure: none; clears and config are accepted every cycle, config has priority.
module ms_ptimer_chan #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 cfg_we,
    input  logic [CNT_WIDTH-1:0] cfg_period,
    input  logic                 cfg_en,
    input  logic                 clr_ready,
    input  logic                 clr_missed,
    output logic                 ready,
    output logic                 missed,
    output logic                 enable
);

    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic                 enable_q, enable_d;
    logic                 ready_q,  ready_d;
    logic                 missed_q, missed_d;
    logic                 expire;

    // Next-state: countdown/expiry, then clears (clear is ordered before expiry), config overrides all
    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        enable_d = enable_q;
        expire   = enable_q & tick & (count_q == ONE);

        if (enable_q && tick) begin
            if (count_q > ONE) begin
                count_d = count_q - ONE;
            end else if (expire) begin
                count_d = period_q;
            end
        end

        // A clear in the expiry cycle happens first, so the expiry is not a miss
        ready_d  = (ready_q & ~clr_ready) | expire;
        // A fresh miss beats a simultaneous clear of the missed flag
        missed_d = (missed_q & ~clr_missed) | (expire & ready_q & ~clr_ready);

        if (cfg_we) begin
            period_d = cfg_period;
            count_d  = cfg_period;
            enable_d = cfg_en & (cfg_period != '0);
            ready_d  = 1'b0;
            missed_d = 1'b0;
        end
    end

    // State registers with synchronous reset; reset also masks any tick in that cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q <= '0;
            count_q  <= '0;
            enable_q <= 1'b0;
            ready_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
            enable_q <= enable_d;
            ready_q  <= ready_d;
            missed_q <= missed_d;
        end
    end

    assign ready  = ready_q;
    assign missed = missed_q;
    assign enable = enable_q;

endmodule

// File: rtl/ms_ptimers.sv
// Purpose: bank of NUM_TIMERS periodic ms timers on the IO bus with per-timer elapsed flags.
// Latency: single-cycle IO access (ack = stb); ready visible the cycle after the expiring tick.
// Backpressure: none; every strobe completes in its own cycle, reads have no side effects.
module ms_ptimers
    import ms_ptimers_pkg::*;
#(
    parameter int NUM_TIMERS = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic        addr,
    input  logic [31:0] data_in,
    input  logic        ms_tick,
    output logic [31:0] data_out,
    output logic        ack,
    output logic        tick_pending
);

    logic                  wr_cfg;
    logic                  wr_clr;
    logic                  rd;
    logic [INDEX_W-1:0]    cfg_index;
    logic [CNT_WIDTH-1:0]  cfg_period;
    logic                  cfg_en;
    logic [NUM_TIMERS-1:0] ready_vec;
    logic [NUM_TIMERS-1:0] missed_vec;
    logic [NUM_TIMERS-1:0] enable_vec;
    logic                  unused_data;

    assign wr_cfg     = stb & we & (addr == ADDR_CFG);
    assign wr_clr     = stb & we & (addr == ADDR_CLR);
    assign rd         = stb & ~we;
    assign cfg_index  = data_in[INDEX_LSB +: INDEX_W];
    assign cfg_period = data_in[PERIOD_LSB +: CNT_WIDTH];
    assign cfg_en     = data_in[EN_BIT];
    // Not every data_in bit is a register field
    assign unused_data = ^data_in;

    // Indices at or above NUM_TIMERS match no channel, so such CFG writes fall away
    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        ms_ptimer_chan #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .tick       (ms_tick),
            .cfg_we     (wr_cfg && (cfg_index == INDEX_W'(i))),
            .cfg_period (cfg_period),
            .cfg_en     (cfg_en),
            .clr_ready  (wr_clr & data_in[i]),
            .clr_missed (wr_clr & data_in[MISSED_LSB + i]),
            .ready      (ready_vec[i]),
            .missed     (missed_vec[i]),
            .enable     (enable_vec[i])
        );
    end

    // Read mux: STAT or enable mask, zero when not reading
    always_comb begin
        data_out = '0;
        if (rd) begin
            if (addr == ADDR_CFG) begin
                data_out[0 +: FLAG_W]          = FLAG_W'(ready_vec);
                data_out[MISSED_LSB +: FLAG_W] = FLAG_W'(missed_vec);
            end else begin
                data_out[0 +: FLAG_W] = FLAG_W'(enable_vec);
            end
        end
    end

    assign ack          = stb;
    assign tick_pending = |(ready_vec & enable_vec);

endmodule

// File: tb/tb_ms_ptimers.sv
module tb_ms_ptimers;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic        addr;
    logic [31:0] data_in;
    logic        ms_tick;
    logic [31:0] data_out;
    logic        ack;
    logic        tick_pending;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ms_ptimers #(
        .NUM_TIMERS (8),
        .CNT_WIDTH  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stb          (stb),
        .we           (we),
        .addr         (addr),
        .data_in      (data_in),
        .ms_tick      (ms_tick),
        .data_out     (data_out),
        .ack          (ack),
        .tick_pending (tick_pending)
    );

    typedef struct {
        logic        s;
        logic        w;
        logic        a;
        logic [31:0] d;
        logic        t;
        logic [31:0] exp_do;
        logic        exp_tp;
    } vec_t;

    vec_t vt[$];

    function automatic logic [31:0] cfg(input int idx, input int per, input bit en);
        return (en ? 32'h0100_0000 : 32'h0) | (32'(idx) << 16) | (32'(per) & 32'h0000_FFFF);
    endfunction

    function automatic void add(input logic s, input logic w, input logic a,
                                input logic [31:0] d, input logic t,
                                input logic [31:0] e, input logic p);
        vec_t v;
        v.s = s; v.w = w; v.a = a; v.d = d; v.t = t; v.exp_do = e; v.exp_tp = p;
        vt.push_back(v);
    endfunction

    // read addr 0 / addr 1, optionally with a tick in the same cycle
    function automatic void rd0(input logic t, input logic [31:0] e, input logic p);
        add(1'b1, 1'b0, 1'b0, 32'h0, t, e, p);
    endfunction
    function automatic void rd1(input logic t, input logic [31:0] e, input logic p);
        add(1'b1, 1'b0, 1'b1, 32'h0, t, e, p);
    endfunction
    function automatic void wr(input logic a, input logic [31:0] d, input logic t, input logic p);
        add(1'b1, 1'b1, a, d, t, 32'h0, p);
    endfunction

    task automatic check(input string nm, input logic [33:0] got, input logic [33:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: {ack,tick_pending,data_out} got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic apply(input string nm, input logic s, input logic w, input logic a,
                         input logic [31:0] d, input logic t,
                         input logic [31:0] e, input logic p);
        stb = s; we = w; addr = a; data_in = d; ms_tick = t;
        @(negedge clk);
        check(nm, {ack, tick_pending, data_out}, {s, p, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; addr = 1'b0; data_in = 32'h0; ms_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        rd0(1'b0, 32'h0, 1'b0);
        rd1(1'b0, 32'h0, 1'b0);
        // timer 2, period 3: ready exactly after 3rd tick
        wr(1'b0, cfg(2, 3, 1), 1'b0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b0, 32'h0000_0004, 1'b1);
        rd1(1'b0, 32'h0000_0004, 1'b1);
        // second expiry without clear -> missed
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b0, 32'h0004_0004, 1'b1);
        add(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // clear missed only
        wr(1'b1, 32'h0004_0000, 1'b0, 1'b1);
        rd0(1'b0, 32'h0000_0004, 1'b1);
        // clear ready in the expiry cycle: ready stays, no miss
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b1, 32'h0000_0004, 1'b1);
        wr(1'b1, 32'h0000_0004, 1'b1, 1'b1);
        rd0(1'b0, 32'h0000_0004, 1'b1);
        // expire again with ready set -> missed
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b1, 32'h0000_0004, 1'b1);
        rd0(1'b0, 32'h0004_0004, 1'b1);
        // clear missed in a cycle with a new miss: miss wins
        rd0(1'b1, 32'h0004_0004, 1'b1);
        rd0(1'b1, 32'h0004_0004, 1'b1);
        wr(1'b1, 32'h0004_0000, 1'b1, 1'b1);
        rd0(1'b0, 32'h0004_0004, 1'b1);
        // clear both
        wr(1'b1, 32'h0004_0004, 1'b0, 1'b1);
        rd0(1'b0, 32'h0, 1'b0);
        // CFG in the expiry cycle wins, reload with period 5
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        wr(1'b0, cfg(2, 5, 1), 1'b1, 1'b0);
        rd0(1'b0, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b0, 32'h0000_0004, 1'b1);
        wr(1'b1, 32'h0000_0004, 1'b0, 1'b1);
        rd0(1'b0, 32'h0, 1'b0);
        // disable timer 2, period 0 on timer 0 forces disable
        wr(1'b0, cfg(2, 5, 0), 1'b0, 1'b0);
        wr(1'b0, cfg(0, 0, 1), 1'b0, 1'b0);
        rd1(1'b0, 32'h0, 1'b0);
        // index 15 is out of range: no effect
        wr(1'b0, cfg(15, 1, 1), 1'b0, 1'b0);
        rd1(1'b0, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b1, 32'h0, 1'b0);
        rd0(1'b0, 32'h0, 1'b0);
        rd1(1'b0, 32'h0, 1'b0);

        for (int i = 0; i < vt.size(); i++) begin
            apply($sformatf("vec%0d", i), vt[i].s, vt[i].w, vt[i].a, vt[i].d, vt[i].t,
                  vt[i].exp_do, vt[i].exp_tp);
        end

        // 100 ticks with timer 0 at period 0: nothing ever fires
        for (int i = 0; i < 100; i++) begin
            apply("p0_noexp", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        end
        apply("p0_stat", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        // all 8 timers with period i+1, 3 ticks -> ready 0x07, missed 0x01
        for (int i = 0; i < 8; i++) begin
            apply("cfg_all", 1'b1, 1'b1, 1'b0, cfg(i, i + 1, 1), 1'b0, 32'h0, 1'b0);
        end
        apply("all_t1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        apply("all_t2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        apply("all_t3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        apply("all_stat", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0001_0007, 1'b1);
        apply("all_en", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0000_00FF, 1'b1);

        // reset mid-count, with a tick that must be ignored
        stb = 1'b0; ms_tick = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; ms_tick = 1'b0;
        apply("rst_stat", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        apply("rst_en", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        apply("rst_tick", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        apply("post_stat", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        apply("post_en", 1'b1, 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
